// File: rtl/axi_device_responder.sv
// AXI4 single-beat slave exposing a word-addressed scratch register bank on the device bus.
// Independent read and write channels, each with one outstanding transaction and fixed latency.
module axi_device_responder #(
  parameter logic [63:0] BASE   = 64'ha000_0000,
  parameter int unsigned AW     = 6,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ar_valid,
  output logic        io_ar_ready,
  input  logic [63:0] io_ar_addr,
  input  logic [7:0]  io_ar_len,
  input  logic [2:0]  io_ar_size,
  input  logic [1:0]  io_ar_burst,
  output logic        io_r_valid,
  input  logic        io_r_ready,
  output logic [63:0] io_r_rdata,
  output logic [1:0]  io_r_rresp,
  input  logic        io_aw_valid,
  output logic        io_aw_ready,
  input  logic [63:0] io_aw_addr,
  input  logic [7:0]  io_aw_len,
  input  logic [2:0]  io_aw_size,
  input  logic [1:0]  io_aw_burst,
  input  logic        io_w_valid,
  output logic        io_w_ready,
  input  logic [63:0] io_w_data,
  input  logic [7:0]  io_w_strb,
  input  logic        io_w_last,
  output logic        io_b_valid,
  input  logic        io_b_ready,
  output logic [1:0]  io_b_bresp
);

  localparam int unsigned Words = 2 ** AW;
  localparam logic [63:0] Span  = 64'd4 << AW;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WWait, WResp} w_state_e;

  logic [31:0] bank_q [Words];

  // Address decode for both channels
  logic [63:0]   ar_off, aw_off;
  logic          ar_err, aw_err;
  logic [AW-1:0] ar_idx, aw_idx;

  assign ar_off = io_ar_addr - BASE;
  assign aw_off = io_aw_addr - BASE;
  assign ar_idx = ar_off[AW+1:2];
  assign aw_idx = aw_off[AW+1:2];
  assign ar_err = (io_ar_addr < BASE) || (ar_off >= Span) || (io_ar_addr[1:0] != 2'b00) ||
                  (io_ar_len != 8'd0) || (io_ar_size > 3'd2);
  assign aw_err = (io_aw_addr < BASE) || (aw_off >= Span) || (io_aw_addr[1:0] != 2'b00) ||
                  (io_aw_len != 8'd0) || (io_aw_size > 3'd2);

  logic unused_ok;
  assign unused_ok = ^{io_ar_burst, io_aw_burst, io_w_data[63:32], io_w_strb[7:4], io_w_last};

  // Read channel
  r_state_e      r_state_q;
  logic [3:0]    r_cnt_q;
  logic [AW-1:0] r_idx_q;
  logic          r_err_q;
  logic          ar_ready_q, r_valid_q;
  logic [63:0]   r_rdata_q;
  logic [1:0]    r_rresp_q;

  logic [AW-1:0] rd_idx_sel;
  logic          rd_err_sel;
  logic [63:0]   rd_sample;

  // With zero latency the response is loaded straight from the AR handshake
  always_comb begin
    rd_idx_sel = r_idx_q;
    rd_err_sel = r_err_q;
    if (r_state_q == RIdle) begin
      rd_idx_sel = ar_idx;
      rd_err_sel = ar_err;
    end
  end

  assign rd_sample = rd_err_sel ? 64'h0 : {32'h0, bank_q[rd_idx_sel]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state_q  <= RIdle;
      r_cnt_q    <= 4'd0;
      r_idx_q    <= '0;
      r_err_q    <= 1'b0;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_rdata_q  <= 64'h0;
      r_rresp_q  <= RespOkay;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (io_ar_valid) begin
            r_idx_q    <= ar_idx;
            r_err_q    <= ar_err;
            ar_ready_q <= 1'b0;
            if (RD_LAT == 0) begin
              r_state_q <= RResp;
              r_valid_q <= 1'b1;
              r_rdata_q <= rd_sample;
              r_rresp_q <= rd_err_sel ? RespSlvErr : RespOkay;
            end else begin
              r_state_q <= RWait;
              r_cnt_q   <= 4'(RD_LAT - 1);
            end
          end
        end
        RWait: begin
          if (r_cnt_q == 4'd0) begin
            r_state_q <= RResp;
            r_valid_q <= 1'b1;
            r_rdata_q <= rd_sample;
            r_rresp_q <= rd_err_sel ? RespSlvErr : RespOkay;
          end else begin
            r_cnt_q <= r_cnt_q - 4'd1;
          end
        end
        RResp: begin
          if (io_r_ready) begin
            r_state_q  <= RIdle;
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  assign io_ar_ready = ar_ready_q;
  assign io_r_valid  = r_valid_q;
  assign io_r_rdata  = r_rdata_q;
  assign io_r_rresp  = r_rresp_q;

  // Write channel; owns the bank
  w_state_e      w_state_q;
  logic [3:0]    w_cnt_q;
  logic [AW-1:0] w_idx_q;
  logic          w_err_q;
  logic          aw_ready_q, w_ready_q, b_valid_q;
  logic [1:0]    b_bresp_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      w_state_q  <= WIdle;
      w_cnt_q    <= 4'd0;
      w_idx_q    <= '0;
      w_err_q    <= 1'b0;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_bresp_q  <= RespOkay;
      for (int i = 0; i < Words; i++) begin
        bank_q[i] <= 32'h0;
      end
    end else begin
      unique case (w_state_q)
        WIdle: begin
          if (io_aw_valid) begin
            w_idx_q    <= aw_idx;
            w_err_q    <= aw_err;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            w_state_q  <= WData;
          end
        end
        WData: begin
          if (io_w_valid) begin
            w_ready_q <= 1'b0;
            if (!w_err_q) begin
              for (int b = 0; b < 4; b++) begin
                if (io_w_strb[b]) bank_q[w_idx_q][8*b +: 8] <= io_w_data[8*b +: 8];
              end
            end
            if (WR_LAT == 0) begin
              w_state_q <= WResp;
              b_valid_q <= 1'b1;
              b_bresp_q <= w_err_q ? RespSlvErr : RespOkay;
            end else begin
              w_state_q <= WWait;
              w_cnt_q   <= 4'(WR_LAT - 1);
            end
          end
        end
        WWait: begin
          if (w_cnt_q == 4'd0) begin
            w_state_q <= WResp;
            b_valid_q <= 1'b1;
            b_bresp_q <= w_err_q ? RespSlvErr : RespOkay;
          end else begin
            w_cnt_q <= w_cnt_q - 4'd1;
          end
        end
        WResp: begin
          if (io_b_ready) begin
            w_state_q  <= WIdle;
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  assign io_aw_ready = aw_ready_q;
  assign io_w_ready  = w_ready_q;
  assign io_b_valid  = b_valid_q;
  assign io_b_bresp  = b_bresp_q;

endmodule
